// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing block: FSM encodings and pin polarity.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_e;

    // Maps a logical "lit" to the pin value for the board's LED polarity.
    function automatic logic led_pin(input logic lit, input bit active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM: counter, level compare, registered lit flag, per-pin polarity.
module led_pwm_core
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 6,
    parameter int PWM_BITS       = 8,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic [PWM_BITS-1:0] i_level,
    output logic [NUM_LEDS-1:0] o_led
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                lit_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            pwm_cnt <= '0;
            lit_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            lit_q   <= (pwm_cnt < i_level);
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pin
        assign o_led[g] = led_pin(lit_q, LED_ACTIVE_LOW);
    end

endmodule

// File: rtl/led_breathe.sv
// Breathing LED: tick-driven rise/hold/fall/hold level sequencer feeding a PWM core.
module led_breathe
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 6,
    parameter int PWM_BITS       = 8,
    parameter int STEP           = 8,
    parameter int HOLD_TICKS     = 4,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_tick,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_peak,
    output logic                o_trough
);

    localparam int MAX_I = (1 << PWM_BITS) - 1;
    localparam int HC_W  = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);

    localparam logic [PWM_BITS-1:0] MAX_V    = PWM_BITS'(MAX_I);
    localparam logic [PWM_BITS-1:0] STEP_V   = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_W    = (PWM_BITS+1)'(MAX_I);
    localparam logic [HC_W-1:0]     HOLD_END = (HOLD_TICKS == 0) ? '0 : HC_W'(HOLD_TICKS - 1);
    localparam bit                  NO_HOLD  = (HOLD_TICKS == 0);

    if (STEP < 1 || STEP > MAX_I) begin : g_bad_step
        $error("led_breathe: STEP out of range 1..2^PWM_BITS-1");
    end

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                peak_d, trough_d;
    logic [PWM_BITS:0]   sum;
    logic                hold_done;

    // Widened by one bit so the saturation test can see overflow past MAX.
    assign sum       = {1'b0, level_q} + STEP_W;
    assign hold_done = NO_HOLD || (hold_q == HOLD_END);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            hold_q   <= '0;
            o_peak   <= 1'b0;
            o_trough <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            o_peak   <= peak_d;
            o_trough <= trough_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        hold_d   = hold_q;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        if (!i_en) begin
            state_d = ST_IDLE;
            level_d = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RISE;
                    level_d = '0;
                    hold_d  = '0;
                end
                ST_RISE: if (i_tick) begin
                    if (sum >= MAX_W) begin
                        level_d = MAX_V;
                        hold_d  = '0;
                        state_d = ST_HOLD_HI;
                        peak_d  = 1'b1;
                    end else begin
                        level_d = sum[PWM_BITS-1:0];
                    end
                end
                ST_HOLD_HI: if (i_tick) begin
                    if (hold_done) state_d = ST_FALL;
                    else           hold_d  = hold_q + 1'b1;
                end
                ST_FALL: if (i_tick) begin
                    if (level_q <= STEP_V) begin
                        level_d  = '0;
                        hold_d   = '0;
                        state_d  = ST_HOLD_LO;
                        trough_d = 1'b1;
                    end else begin
                        level_d = level_q - STEP_V;
                    end
                end
                ST_HOLD_LO: if (i_tick) begin
                    if (hold_done) state_d = ST_RISE;
                    else           hold_d  = hold_q + 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign o_level = level_q;

    led_pwm_core #(
        .NUM_LEDS      (NUM_LEDS),
        .PWM_BITS      (PWM_BITS),
        .LED_ACTIVE_LOW(LED_ACTIVE_LOW)
    ) u_pwm (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_run  (i_en && (state_q != ST_IDLE)),
        .i_level(level_q),
        .o_led  (o_led)
    );

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench: two configurations (hold of 2 ticks / no hold) against hand-computed values.
module tb_led_breathe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, tick_a, en_b, tick_b;
    logic [5:0] led_a, led_b;
    logic [3:0] lvl_a, lvl_b;
    logic       peak_a, trough_a, peak_b, trough_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_breathe #(.NUM_LEDS(6), .PWM_BITS(4), .STEP(4), .HOLD_TICKS(2), .LED_ACTIVE_LOW(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_tick(tick_a),
        .o_led(led_a), .o_level(lvl_a), .o_peak(peak_a), .o_trough(trough_a)
    );

    led_breathe #(.NUM_LEDS(6), .PWM_BITS(4), .STEP(5), .HOLD_TICKS(0), .LED_ACTIVE_LOW(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_tick(tick_b),
        .o_led(led_b), .o_level(lvl_b), .o_peak(peak_b), .o_trough(trough_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_a();
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
    endtask

    task automatic pulse_b();
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
    endtask

    // Counts cycles with dut_a LEDs lit over a 16-cycle window; flags mixed pins.
    task automatic count_lit(output int lit, output int bad);
        lit = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (led_a == 6'h00)      lit++;
            else if (led_a != 6'h3F) bad++;
        end
    endtask

    int lit, bad;

    initial begin
        rst = 1'b1; en_a = 1'b0; tick_a = 1'b0; en_b = 1'b0; tick_b = 1'b0;
        idle(2);
        chk("rst_level", lvl_a, 0);
        chk("rst_led", led_a, 6'h3F);
        chk("rst_peak", peak_a, 0);
        chk("rst_trough", trough_a, 0);

        rst = 1'b0; en_a = 1'b1;
        step();
        pulse_a(); chk("rise_4", lvl_a, 4);
        idle(3);
        pulse_a(); chk("rise_8", lvl_a, 8);
        idle(3);

        // Reset mid-RISE wins over enable.
        rst = 1'b1; tick_a = 1'b1;
        step();
        rst = 1'b0; tick_a = 1'b0;
        chk("rst_mid_level", lvl_a, 0);
        chk("rst_mid_led", led_a, 6'h3F);
        step();
        chk("restart_level", lvl_a, 0);
        pulse_a(); chk("restart_4", lvl_a, 4);

        idle(3); pulse_a(); chk("ramp_8", lvl_a, 8); chk("ramp_8_peak", peak_a, 0);
        idle(3); pulse_a(); chk("ramp_12", lvl_a, 12);
        idle(3); pulse_a(); chk("ramp_15", lvl_a, 15); chk("peak_pulse", peak_a, 1);
        chk("peak_not_trough", trough_a, 0);
        step(); chk("peak_one_cycle", peak_a, 0);

        idle(3); pulse_a(); chk("hold_hi_1", lvl_a, 15);
        idle(3); pulse_a(); chk("hold_hi_2", lvl_a, 15);
        idle(3); pulse_a(); chk("fall_11", lvl_a, 11);
        idle(3); pulse_a(); chk("fall_7", lvl_a, 7);
        idle(3); pulse_a(); chk("fall_3", lvl_a, 3); chk("fall_3_trough", trough_a, 0);
        idle(3); pulse_a(); chk("fall_0", lvl_a, 0); chk("trough_pulse", trough_a, 1);
        chk("trough_not_peak", peak_a, 0);
        step(); chk("trough_one_cycle", trough_a, 0);
        idle(3); pulse_a(); chk("hold_lo_1", lvl_a, 0);
        idle(3); pulse_a(); chk("hold_lo_2", lvl_a, 0);
        idle(3); pulse_a(); chk("rise_again_4", lvl_a, 4);

        count_lit(lit, bad);
        chk("duty_4", lit, 4);
        chk("duty_4_pins", bad, 0);

        pulse_a(); pulse_a(); pulse_a(); chk("to_peak", lvl_a, 15);
        count_lit(lit, bad);
        chk("duty_15", lit, 15);
        chk("duty_15_pins", bad, 0);

        // Disable during HOLD_HI with a tick in the same cycle.
        en_a = 1'b0; tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        chk("dis_level", lvl_a, 0);
        chk("dis_led", led_a, 6'h3F);
        chk("dis_trough", trough_a, 0);
        chk("dis_peak", peak_a, 0);
        count_lit(lit, bad);
        chk("duty_idle", lit + bad, 0);

        en_a = 1'b1;
        step(); chk("reen_level", lvl_a, 0);
        count_lit(lit, bad);
        chk("duty_0", lit + bad, 0);

        // Back-to-back ticks each count once.
        tick_a = 1'b1;
        step(); chk("b2b_4", lvl_a, 4);
        step(); chk("b2b_8", lvl_a, 8);
        step(); chk("b2b_12", lvl_a, 12);
        tick_a = 1'b0;
        step(); chk("b2b_stop", lvl_a, 12);

        // No-hold configuration, STEP=5.
        en_b = 1'b1;
        step();
        pulse_b(); chk("nh_5", lvl_b, 5);
        idle(2); pulse_b(); chk("nh_10", lvl_b, 10);
        idle(2); pulse_b(); chk("nh_15", lvl_b, 15); chk("nh_peak", peak_b, 1);
        idle(2); pulse_b(); chk("nh_hold", lvl_b, 15); chk("nh_peak_off", peak_b, 0);
        idle(2); pulse_b(); chk("nh_10f", lvl_b, 10);
        idle(2); pulse_b(); chk("nh_5f", lvl_b, 5);
        idle(2); pulse_b(); chk("nh_0", lvl_b, 0); chk("nh_trough", trough_b, 1);
        idle(2); pulse_b(); chk("nh_hold_lo", lvl_b, 0); chk("nh_trough_off", trough_b, 0);
        idle(2); pulse_b(); chk("nh_rise_5", lvl_b, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_breathe.md
Name: led_breathe

Overview:
- Downstream consumer of the board's blink/tick counter stage.
- Takes a one-cycle step strobe from the counter and produces a "breathing" LED effect. Brightness ramps up, holds, ramps down and holds, driven by a free-running PWM.
- Drives the board LED bank directly. Targets the 27 MHz board clock.

Parameters:
- NUM_LEDS, 6, number of LED outputs; all carry the same PWM waveform.
- PWM_BITS, 8, width of the PWM counter and brightness level; MAX = 2^PWM_BITS-1.
- STEP, 8, level increment/decrement per accepted tick; legal range 1..MAX.
- HOLD_TICKS, 4, ticks spent at the peak and at the trough; 0 means no hold.
- LED_ACTIVE_LOW, 1, when 1 the LED pins are inverted (pin 0 = lit).

Ports:
- i_clk  input  1  board clock.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  enable; low forces dark/idle.
- i_tick  input  1  one-cycle step strobe from the upstream counter.
- o_led  output  NUM_LEDS  LED pins, polarity per LED_ACTIVE_LOW.
- o_level  output  PWM_BITS  current brightness level.
- o_peak  output  1  one-cycle pulse on entering HOLD_HI.
- o_trough  output  1  one-cycle pulse on entering HOLD_LO.

Behaviour:
- Interface (already decided): one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset (i_rst=1 at posedge):
  - state=IDLE, level=0, pwm_cnt=0, hold_cnt=0.
  - o_peak=0, o_trough=0.
  - o_led all unlit (all 1s if LED_ACTIVE_LOW, else all 0s).
  - Reset wins over every other input in the same cycle.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments every cycle while state!=IDLE and wraps MAX->0.
  - Held at 0 in IDLE.
- LED output:
  - lit = (pwm_cnt < level), registered, so o_led lags pwm_cnt by 1 cycle.
  - level=0 gives never lit; level=MAX gives lit MAX of every 2^PWM_BITS cycles.
- o_level is the level register; no extra latency.
- FSM states: IDLE, RISE, HOLD_HI, FALL, HOLD_LO. Transitions are evaluated only on cycles with i_tick=1, except the enable handling below.
  - IDLE: i_en=1 -> RISE with level=0. i_tick is ignored in this transition cycle.
  - RISE:
    - if level+STEP >= MAX: level<=MAX, hold_cnt<=0, -> HOLD_HI, o_peak=1 for that cycle.
    - else: level<=level+STEP.
    - Compute the sum at PWM_BITS+1 width; no wrap allowed.
  - HOLD_HI: if HOLD_TICKS==0 or hold_cnt==HOLD_TICKS-1 -> FALL; else hold_cnt++.
  - FALL:
    - if level <= STEP: level<=0, hold_cnt<=0, -> HOLD_LO, o_trough=1.
    - else: level<=level-STEP.
    - No underflow allowed.
  - HOLD_LO: same counting rule as HOLD_HI, then -> RISE.
- HOLD_TICKS==0 case:
  - The hold state is still entered and the pulse still fires.
  - The hold state exits on the next tick, so the level sits at MAX or 0 for exactly one tick interval.
- i_en=0 in any state:
  - Next cycle: state=IDLE, level=0, pwm_cnt=0, LEDs unlit, no o_peak/o_trough pulse.
  - i_tick in the same cycle is ignored.
- i_en re-asserted mid-cycle: always restarts from RISE at level 0. No resume from the prior level.
- i_tick asserted on consecutive cycles: each cycle counts as a separate step.
- o_peak/o_trough: never high together; never high for more than 1 cycle per entry.
- Elaboration check: STEP must be in 1..MAX; otherwise elaboration fails.

Decomposition:
- Shared package/include led_pkg:
  - FSM state encodings (3-bit localparams ST_IDLE..ST_HOLD_LO).
  - Polarity helper constant.
- Sub-module led_pwm_core:
  - Owns pwm_cnt, the compare, the output register and the polarity inversion.
  - Inputs: i_clk, i_rst, i_run, i_level. Output: o_led.
- led_breathe holds the FSM, level and hold counters.

Test Plan (PWM_BITS=4, STEP=4, HOLD_TICKS=2, NUM_LEDS=6, LED_ACTIVE_LOW=1 unless noted):
- Reset mid-RISE at level=8 -> next cycle o_level=0, o_led=6'b111111, state IDLE; release with i_en=1 -> RISE from 0.
- i_en=1, ticks every 20 cycles -> o_level after each tick: 4,8,12,15.
  - o_peak pulses once, on the 4th tick's cycle.
  - Then 2 ticks hold at 15, then 11,7,3,0 with o_trough on reaching 0.
  - Then 2 ticks hold, then 4 again.
- Level=4 steady -> over any 16-cycle window o_led is low (lit) exactly 4 cycles, 1 cycle after pwm_cnt 0..3; level=15 -> lit 15/16; level=0 -> never lit.
- i_en dropped during HOLD_HI with i_tick high in the same cycle -> IDLE next cycle, o_level=0, no o_trough, LEDs dark.
- HOLD_TICKS=0, STEP=5:
  - Rising levels 5,10,15: 10+5 saturates to 15 exactly, and o_peak fires.
  - The next tick starts FALL: 10,5,0, with o_trough at 0.
- Ticks on back-to-back cycles -> level advances by STEP every cycle; no tick is missed or double-counted.
